// File: rtl/hazard_forward_unit_pkg.sv
// Shared definitions for the hazard/forwarding controller: default opcodes,
// FSM state encoding and forward-select encoding.
package hazard_forward_unit_pkg;

  localparam logic [3:0] OPC_NOP_DEF   = 4'b0000;
  localparam logic [3:0] OPC_ST_DEF    = 4'b1011;
  localparam logic [3:0] OPC_LD_DEF    = 4'b1010;
  localparam logic [3:0] OPC_NORS2_DEF = 4'b1001;

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_e;

endpackage

// File: rtl/hfu_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module hfu_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_forward_unit.sv
// Operand forwarding, load-use/interlock stalls, memory-wait freeze with a
// watchdog, and saturating stall/bubble performance counters.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int              RA_W      = 3,
  parameter int              OPC_W     = 4,
  parameter logic [OPC_W-1:0] OPC_NOP   = OPC_NOP_DEF,
  parameter logic [OPC_W-1:0] OPC_ST    = OPC_ST_DEF,
  parameter logic [OPC_W-1:0] OPC_LD    = OPC_LD_DEF,
  parameter logic [OPC_W-1:0] OPC_NORS2 = OPC_NORS2_DEF,
  parameter int              CNT_W     = 16,
  parameter int              TIMEOUT   = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RA_W-1:0]  rs1,
  input  logic [RA_W-1:0]  rs2,
  input  logic [OPC_W-1:0] opc_id,
  input  logic [RA_W-1:0]  rd_ex,
  input  logic [RA_W-1:0]  rd_mem,
  input  logic [RA_W-1:0]  rd_wb,
  input  logic [OPC_W-1:0] opc_ex,
  input  logic [OPC_W-1:0] opc_mem,
  input  logic [OPC_W-1:0] opc_wb,
  input  logic             forward_en,
  input  logic             mem_ready,
  input  logic             perf_clr,
  output logic             stall,
  output logic             bubble_ex,
  output logic             freeze,
  output logic [1:0]       forward_A,
  output logic [1:0]       forward_B,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] luse_cnt
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  function automatic logic writes(input logic [OPC_W-1:0] opc);
    return (opc != OPC_NOP) && (opc != OPC_ST);
  endfunction

  function automatic logic hit(input logic wr, input logic [RA_W-1:0] rd,
                               input logic [RA_W-1:0] rs);
    return wr && (rd == rs) && (rd != '0);
  endfunction

  function automatic fwd_sel_e pick(input logic off, input logic ex,
                                    input logic mem, input logic wb);
    if (off)      return FWD_RF;
    else if (ex)  return FWD_EX;
    else if (mem) return FWD_MEM;
    else if (wb)  return FWD_WB;
    else          return FWD_RF;
  endfunction

  logic wr_ex, wr_mem, wr_wb, rs2_src, ex_fwd_ok, mem_acc, fwd_off;
  logic hz_ex_1, hz_ex_2, hz_mem_1, hz_mem_2, hz_wb_1, hz_wb_2;
  logic luse, intl;

  assign wr_ex   = writes(opc_ex);
  assign wr_mem  = writes(opc_mem);
  assign wr_wb   = writes(opc_wb);
  assign rs2_src = (opc_id != OPC_NORS2);

  assign hz_ex_1  = hit(wr_ex, rd_ex, rs1);
  assign hz_mem_1 = hit(wr_mem, rd_mem, rs1);
  assign hz_wb_1  = hit(wr_wb, rd_wb, rs1);
  assign hz_ex_2  = rs2_src && hit(wr_ex, rd_ex, rs2);
  assign hz_mem_2 = rs2_src && hit(wr_mem, rd_mem, rs2);
  assign hz_wb_2  = rs2_src && hit(wr_wb, rd_wb, rs2);

  // A load in EX has no result yet, so it can never be a forwarding source.
  assign ex_fwd_ok = (opc_ex != OPC_LD);
  assign mem_acc   = (opc_mem == OPC_LD) || (opc_mem == OPC_ST);
  assign freeze    = mem_acc && !mem_ready && !rst;
  assign fwd_off   = !forward_en || freeze || rst;

  assign forward_A = pick(fwd_off, hz_ex_1 && ex_fwd_ok, hz_mem_1, hz_wb_1);
  assign forward_B = pick(fwd_off, hz_ex_2 && ex_fwd_ok, hz_mem_2, hz_wb_2);

  assign luse      = (opc_ex == OPC_LD) && (hz_ex_1 || hz_ex_2);
  assign intl      = !forward_en &&
                     (hz_ex_1 || hz_ex_2 || hz_mem_1 || hz_mem_2 || hz_wb_1 || hz_wb_2);
  assign stall     = (freeze || luse || intl) && !rst;
  assign bubble_ex = stall && !freeze;

  logic [0:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              timeout_q, timeout_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:      if (freeze) state_d = ST_MEM_WAIT;
      ST_MEM_WAIT: if (mem_ready) state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase
  end

  // wait_q counts consecutive frozen cycles, including the one that enters MEM_WAIT.
  always_comb begin
    wait_d = '0;
    if (state_d == ST_MEM_WAIT) begin
      wait_d = (wait_q == WAIT_W'(TIMEOUT)) ? wait_q : wait_q + 1'b1;
    end
    timeout_d = timeout_q ||
                ((state_q == ST_MEM_WAIT) && (wait_q == WAIT_W'(TIMEOUT - 1)) && freeze);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  assign mem_timeout = timeout_q;

  hfu_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc_i(stall),
    .clr_i(perf_clr),
    .cnt_o(stall_cnt)
  );

  hfu_sat_counter #(.CNT_W(CNT_W)) u_luse_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc_i(luse && !freeze),
    .clr_i(perf_clr),
    .cnt_o(luse_cnt)
  );

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: vector table for the combinational decisions,
// then hand-written sequences for counters, FSM, watchdog and reset.
module tb_hazard_forward_unit;
  import hazard_forward_unit_pkg::*;

  localparam logic [3:0] NOP = 4'b0000, ALU = 4'b0001, LD = 4'b1010,
                         ST = 4'b1011, NORS2 = 4'b1001;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] rs1, rs2, rd_ex, rd_mem, rd_wb;
  logic [3:0] opc_id, opc_ex, opc_mem, opc_wb;
  logic       forward_en, mem_ready, perf_clr;
  logic       stall, bubble_ex, freeze, mem_timeout;
  logic [1:0] forward_A, forward_B;
  logic [3:0] stall_cnt, luse_cnt;

  hazard_forward_unit #(.RA_W(3), .OPC_W(4), .CNT_W(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .opc_id(opc_id),
    .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
    .opc_ex(opc_ex), .opc_mem(opc_mem), .opc_wb(opc_wb),
    .forward_en(forward_en), .mem_ready(mem_ready), .perf_clr(perf_clr),
    .stall(stall), .bubble_ex(bubble_ex), .freeze(freeze),
    .forward_A(forward_A), .forward_B(forward_B), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .luse_cnt(luse_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] rs1, rs2;
    logic [3:0] opc_id;
    logic [2:0] rd_ex, rd_mem, rd_wb;
    logic [3:0] opc_ex, opc_mem, opc_wb;
    logic       fen, mr, pclr;
  } stim_t;

  typedef struct packed {
    logic       stall, bubble, freeze;
    logic [1:0] fa, fb;
  } exp_t;

  typedef struct packed {
    stim_t s;
    exp_t  e;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  vec_t tbl[$];
  exp_t sb[$];

  function automatic stim_t base();
    stim_t s;
    s = '0;
    s.opc_id = ALU;
    s.fen    = 1'b1;
    s.mr     = 1'b1;
    return s;
  endfunction

  function automatic exp_t ex(input logic st, input logic bb, input logic fz,
                              input logic [1:0] fa, input logic [1:0] fb);
    exp_t e;
    e.stall = st; e.bubble = bb; e.freeze = fz; e.fa = fa; e.fb = fb;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One cycle: drive after the edge, queue the expectation, compare at negedge.
  task automatic step(input stim_t s, input exp_t e, input logic r, input string tag);
    exp_t got;
    @(posedge clk);
    #1;
    rst = r;
    rs1 = s.rs1; rs2 = s.rs2; opc_id = s.opc_id;
    rd_ex = s.rd_ex; rd_mem = s.rd_mem; rd_wb = s.rd_wb;
    opc_ex = s.opc_ex; opc_mem = s.opc_mem; opc_wb = s.opc_wb;
    forward_en = s.fen; mem_ready = s.mr; perf_clr = s.pclr;
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 1, 0);
    end else begin
      got = sb.pop_front();
      chk({tag, ".stall"},  int'(stall),     int'(got.stall));
      chk({tag, ".bubble"}, int'(bubble_ex), int'(got.bubble));
      chk({tag, ".freeze"}, int'(freeze),    int'(got.freeze));
      chk({tag, ".fwdA"},   int'(forward_A), int'(got.fa));
      chk({tag, ".fwdB"},   int'(forward_B), int'(got.fb));
    end
  endtask

  task automatic add(input stim_t s, input exp_t e);
    vec_t v;
    v.s = s; v.e = e;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    step(base(), ex(0, 0, 0, 2'b00, 2'b00), 1'b1, "rst");
  endtask

  initial begin
    stim_t s, miss;
    rst = 1'b1;
    {rs1, rs2, rd_ex, rd_mem, rd_wb} = '0;
    {opc_id, opc_ex, opc_mem, opc_wb} = '0;
    forward_en = 1'b1; mem_ready = 1'b1; perf_clr = 1'b0;
    repeat (2) @(posedge clk);

    s = base(); s.rs1 = 3; s.rd_ex = 3; s.rd_mem = 3; s.opc_ex = ALU; s.opc_mem = ALU;
    add(s, ex(0, 0, 0, 2'b01, 2'b00));
    s.opc_ex = NOP;
    add(s, ex(0, 0, 0, 2'b10, 2'b00));
    s.rs2 = 5; s.rd_wb = 5; s.opc_wb = ALU;
    add(s, ex(0, 0, 0, 2'b10, 2'b11));
    s = base(); s.opc_ex = LD; s.rd_ex = 2; s.rs2 = 2;
    add(s, ex(1, 1, 0, 2'b00, 2'b00));
    s.opc_id = NORS2;
    add(s, ex(0, 0, 0, 2'b00, 2'b00));
    s.opc_id = ALU; s.rd_mem = 2; s.opc_mem = ALU;
    add(s, ex(1, 1, 0, 2'b00, 2'b10));
    s = base(); s.fen = 0; s.rd_wb = 4; s.rs1 = 4; s.opc_wb = ALU;
    add(s, ex(1, 1, 0, 2'b00, 2'b00));
    s.opc_wb = ST;
    add(s, ex(0, 0, 0, 2'b00, 2'b00));
    s.opc_wb = ALU; s.rd_wb = 0; s.rs1 = 0;
    add(s, ex(0, 0, 0, 2'b00, 2'b00));
    s = base(); s.opc_mem = LD; s.mr = 0; s.rs1 = 3; s.rd_ex = 3; s.opc_ex = ALU;
    add(s, ex(1, 0, 1, 2'b00, 2'b00));
    s = base(); s.opc_mem = ST; s.mr = 0; s.opc_ex = LD; s.rd_ex = 2; s.rs1 = 2;
    add(s, ex(1, 0, 1, 2'b00, 2'b00));
    s = base(); s.opc_ex = ALU;
    add(s, ex(0, 0, 0, 2'b00, 2'b00));
    s = base(); s.opc_id = NORS2; s.rs2 = 5; s.rd_ex = 5; s.opc_ex = ALU;
    add(s, ex(0, 0, 0, 2'b00, 2'b00));
    s.fen = 0;
    add(s, ex(0, 0, 0, 2'b00, 2'b00));
    s = base(); s.fen = 0; s.rs2 = 6; s.rd_mem = 6; s.opc_mem = ALU;
    add(s, ex(1, 1, 0, 2'b00, 2'b00));
    s = base(); s.opc_mem = ALU; s.mr = 0;
    add(s, ex(0, 0, 0, 2'b00, 2'b00));
    s = base(); s.opc_ex = ST; s.rd_ex = 3; s.rs1 = 3;
    add(s, ex(0, 0, 0, 2'b00, 2'b00));
    s = base(); s.rs1 = 7; s.rd_wb = 7; s.opc_wb = LD;
    add(s, ex(0, 0, 0, 2'b11, 2'b00));
    s = base(); s.opc_ex = LD; s.rd_ex = 3; s.rs1 = 3; s.rd_wb = 3; s.opc_wb = ALU;
    add(s, ex(1, 1, 0, 2'b11, 2'b00));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].s, tbl[i].e, 1'b0, $sformatf("vec%0d", i));
    end

    // Reset masks every hazard, then clears counters, FSM and watchdog.
    s = base(); s.opc_mem = LD; s.mr = 0; s.fen = 0; s.rs1 = 4; s.rd_wb = 4; s.opc_wb = ALU;
    step(s, ex(0, 0, 0, 2'b00, 2'b00), 1'b1, "rst_mask");
    step(base(), ex(0, 0, 0, 2'b00, 2'b00), 1'b0, "post_rst");
    chk("rst.stall_cnt", int'(stall_cnt), 0);
    chk("rst.luse_cnt", int'(luse_cnt), 0);
    chk("rst.timeout", int'(mem_timeout), 0);
    chk("rst.state", int'(dut.state_q), int'(ST_RUN));

    // Load-use bubble counting; NORS2 suppresses the rs2 hazard.
    do_reset();
    s = base(); s.opc_ex = LD; s.rd_ex = 2; s.rs2 = 2;
    step(s, ex(1, 1, 0, 2'b00, 2'b00), 1'b0, "luse");
    chk("luse.cnt_before", int'(luse_cnt), 0);
    s.opc_id = NORS2;
    step(s, ex(0, 0, 0, 2'b00, 2'b00), 1'b0, "luse_nors2");
    chk("luse.cnt_after", int'(luse_cnt), 1);
    chk("luse.stall_cnt", int'(stall_cnt), 1);
    s = base(); s.opc_mem = ST; s.mr = 0; s.opc_ex = LD; s.rd_ex = 2; s.rs1 = 2;
    step(s, ex(1, 0, 1, 2'b00, 2'b00), 1'b0, "luse_frz");
    step(base(), ex(0, 0, 0, 2'b00, 2'b00), 1'b0, "luse_frz_end");
    chk("luse_frz.cnt", int'(luse_cnt), 1);
    chk("luse_frz.stall_cnt", int'(stall_cnt), 2);

    // Cache miss: five frozen cycles, release on the first mem_ready.
    do_reset();
    miss = base(); miss.opc_mem = LD; miss.mr = 0;
    for (int i = 0; i < 5; i++) begin
      step(miss, ex(1, 0, 1, 2'b00, 2'b00), 1'b0, $sformatf("miss%0d", i));
      chk($sformatf("miss%0d.state", i), int'(dut.state_q),
          (i == 0) ? int'(ST_RUN) : int'(ST_MEM_WAIT));
    end
    miss.mr = 1;
    step(miss, ex(0, 0, 0, 2'b00, 2'b00), 1'b0, "miss_done");
    chk("miss.stall_cnt", int'(stall_cnt), 5);
    chk("miss.timeout", int'(mem_timeout), 0);
    step(base(), ex(0, 0, 0, 2'b00, 2'b00), 1'b0, "miss_after");
    chk("miss.state_run", int'(dut.state_q), int'(ST_RUN));

    // Watchdog: eight frozen cycles with TIMEOUT=8 raise the sticky flag.
    do_reset();
    miss = base(); miss.opc_mem = ST; miss.mr = 0;
    for (int i = 0; i < 8; i++) begin
      step(miss, ex(1, 0, 1, 2'b00, 2'b00), 1'b0, $sformatf("wd%0d", i));
      chk($sformatf("wd%0d.timeout", i), int'(mem_timeout), 0);
    end
    miss.mr = 1;
    step(miss, ex(0, 0, 0, 2'b00, 2'b00), 1'b0, "wd_rel");
    chk("wd.timeout_set", int'(mem_timeout), 1);
    step(base(), ex(0, 0, 0, 2'b00, 2'b00), 1'b0, "wd_hold");
    chk("wd.timeout_held", int'(mem_timeout), 1);
    chk("wd.stall_cnt", int'(stall_cnt), 8);
    do_reset();
    step(base(), ex(0, 0, 0, 2'b00, 2'b00), 1'b0, "wd_clr");
    chk("wd.timeout_clr", int'(mem_timeout), 0);
    chk("wd.stall_cnt_clr", int'(stall_cnt), 0);
    chk("wd.state", int'(dut.state_q), int'(ST_RUN));

    // Saturation of the 4-bit stall counter, then perf_clr beats increment.
    do_reset();
    s = base(); s.fen = 0; s.rs1 = 4; s.rd_wb = 4; s.opc_wb = ALU;
    for (int i = 0; i < 20; i++) begin
      step(s, ex(1, 1, 0, 2'b00, 2'b00), 1'b0, $sformatf("sat%0d", i));
    end
    s.pclr = 1;
    step(s, ex(1, 1, 0, 2'b00, 2'b00), 1'b0, "sat_clr");
    chk("sat.stall_cnt", int'(stall_cnt), 15);
    step(base(), ex(0, 0, 0, 2'b00, 2'b00), 1'b0, "sat_after");
    chk("sat.cleared", int'(stall_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
